// File: rtl/bwt_stream_ctrl.sv
// bwt_stream_ctrl: receives a sentinel-terminated string, has it suffix-sorted externally,
// and streams back the BWT last column with its primary index.
module bwt_stream_ctrl #(
   parameter int STRING_LEN = 32,
   parameter int ELEM_W = 8,
   parameter int BUS_W = 64,
   parameter logic [ELEM_W-1:0] SENTINEL = 8'h24
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [BUS_W-1:0]                 in_data,
   input  logic                             in_last,
   output logic                             sort_start,
   output logic [STRING_LEN*ELEM_W-1:0]     sort_string,
   input  logic                             sa_valid,
   input  logic [$clog2(STRING_LEN)-1:0]    sa_idx,
   output logic                             sa_ready,
   input  logic                             sort_done,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [BUS_W-1:0]                 out_data,
   output logic                             out_last,
   output logic [$clog2(STRING_LEN)-1:0]    primary_idx,
   output logic                             busy,
   output logic [2:0]                       err
);
   localparam int EPB = BUS_W / ELEM_W;
   localparam int BEATS = STRING_LEN * ELEM_W / BUS_W;
   localparam int IDX_W = $clog2(STRING_LEN);
   localparam int BCW = $clog2(BEATS + 1);
   localparam int SW = STRING_LEN * ELEM_W;

   typedef enum logic [2:0] {IDLE, LOAD, DROP, CHECK, START, COLLECT, SEND} state_t;
   state_t state, nxt;
   logic [BCW-1:0] bcnt, obeat;
   logic [IDX_W:0] rcnt;
   logic done_q, in_fire, sa_fire, out_fire, beat_end, cnt_full, bad_str;
   logic [ELEM_W-1:0] sa_elem;
   logic [ELEM_W-1:0] bwt [STRING_LEN];

   assign in_fire = in_valid & in_ready;
   assign sa_fire = sa_valid & sa_ready;
   assign out_fire = out_valid & out_ready;
   assign beat_end = state == IDLE ? BEATS == 1 : 32'(bcnt) == BEATS - 1;
   assign cnt_full = 32'(rcnt) == STRING_LEN;
   assign sort_start = state == START;
   assign sa_ready = state == COLLECT && !cnt_full;
   assign out_valid = state == SEND;
   assign out_last = out_valid && 32'(obeat) == BEATS - 1;
   assign busy = state != IDLE;
   // rank r takes the element preceding its suffix, wrapping to the sentinel slot
   assign sa_elem = ELEM_W'(sort_string >> (ELEM_W * (sa_idx == '0 ? STRING_LEN - 1 : 32'(sa_idx) - 1)));

   always_comb begin
      bad_str = sort_string[SW-1 -: ELEM_W] != SENTINEL;
      for (int i = 0; i < STRING_LEN - 1; i++)
         bad_str = bad_str | (sort_string[i*ELEM_W +: ELEM_W] == SENTINEL);
   end

   always_comb begin
      out_data = '0;
      for (int i = 0; i < EPB; i++)
         out_data[i*ELEM_W +: ELEM_W] = out_valid ? bwt[IDX_W'(32'(obeat) * EPB + i)] : '0;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE, LOAD: if (in_fire) nxt = in_last ? (beat_end ? CHECK : IDLE) : (beat_end ? DROP : LOAD);
         DROP:       if (in_fire && in_last) nxt = IDLE;
         CHECK:      nxt = bad_str ? IDLE : START;
         START:      nxt = COLLECT;
         COLLECT:    if ((cnt_full || (sa_fire && 32'(rcnt) == STRING_LEN - 1)) && (done_q || sort_done)) nxt = SEND;
         SEND:       if (out_fire && out_last) nxt = IDLE;
         default:    nxt = IDLE;
      endcase
   end

   // in_ready is registered so it reads 0 while reset is held
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         in_ready <= 1'b0;
         sort_string <= '0;
         bcnt <= '0;
         obeat <= '0;
         rcnt <= '0;
         done_q <= 1'b0;
         primary_idx <= '0;
         err <= '0;
      end else begin
         state <= nxt;
         in_ready <= nxt == IDLE || nxt == LOAD || nxt == DROP;
         if (in_fire && state != DROP) begin
            for (int k = 0; k < BEATS; k++)
               if ((state == IDLE ? 0 : 32'(bcnt)) == k) sort_string[k*BUS_W +: BUS_W] <= in_data;
            bcnt <= state == IDLE ? BCW'(1) : bcnt + 1'b1;
            err <= state == IDLE ? {2'b00, in_last != beat_end} : {err[2:1], err[0] | (in_last != beat_end)};
         end
         if (state == CHECK) begin
            err[1] <= err[1] | bad_str;
            done_q <= 1'b0;
            rcnt <= '0;
            obeat <= '0;
         end
         if ((state == START || state == COLLECT) && sort_done) done_q <= 1'b1;
         if (sa_fire) begin
            rcnt <= rcnt + 1'b1;
            if (sa_idx == '0) primary_idx <= rcnt[IDX_W-1:0];
            if (32'(sa_idx) >= STRING_LEN) err[2] <= 1'b1;
         end
         if (out_fire) obeat <= obeat + 1'b1;
      end
   end

   always_ff @(posedge clk)
      if (sa_fire) bwt[rcnt[IDX_W-1:0]] <= 32'(sa_idx) >= STRING_LEN ? SENTINEL : sa_elem;
endmodule

// File: tb/tb_bwt_stream_ctrl.sv
// tb_bwt_stream_ctrl: directed vectors for an 8-element, 32-bit-bus build of bwt_stream_ctrl.
module tb_bwt_stream_ctrl;
   localparam int L = 8;
   localparam int EW = 8;
   localparam int BW = 32;
   localparam int IW = 3;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_last = 1'b0, sa_valid = 1'b0, sort_done = 1'b0, out_ready = 1'b0;
   logic [BW-1:0] in_data = '0;
   logic [IW-1:0] sa_idx = '0;
   logic in_ready, sort_start, sa_ready, out_valid, out_last, busy;
   logic [L*EW-1:0] sort_string;
   logic [BW-1:0] out_data;
   logic [IW-1:0] primary_idx;
   logic [2:0] err;

   int checks = 0, errors = 0, cyc = 0;
   int last_cyc = 0, start_cyc = 0, sa_cyc = 0, first_ov = -1, starts = 0, nstall = 0, s0 = 0;
   logic [BW-1:0] ob[$];
   logic ol[$];
   logic [IW-1:0] op[$];
   logic hold = 1'b0, hl = 1'b0;
   logic [BW-1:0] hd = '0;
   int sa_tab[$] = '{7, 6, 5, 3, 1, 0, 4, 2};

   bwt_stream_ctrl #(.STRING_LEN(L), .ELEM_W(EW), .BUS_W(BW), .SENTINEL(8'h24)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .sort_start(sort_start), .sort_string(sort_string), .sa_valid(sa_valid),
      .sa_idx(sa_idx), .sa_ready(sa_ready), .sort_done(sort_done), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .primary_idx(primary_idx),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (hold) begin
         nstall++;
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_data", 64'(out_data), 64'(hd));
         check("hold_last", 64'(out_last), 64'(hl));
      end
      hold = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid && out_ready) begin
         ob.push_back(out_data);
         ol.push_back(out_last);
         op.push_back(primary_idx);
      end
      if (sort_start) begin
         starts++;
         start_cyc = cyc;
      end
   end

   task automatic check_reset();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_sort_start", 64'(sort_start), 64'd0);
      check("rst_sa_ready", 64'(sa_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_primary", 64'(primary_idx), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_sort_string", 64'(sort_string), 64'd0);
   endtask

   task automatic send_beat(input logic [BW-1:0] d, input logic l);
      int n = 0;
      in_data = d;
      in_last = l;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      if (l) last_cyc = cyc;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic send_sa(input logic [IW-1:0] idx, input logic done, input int gap);
      int n = 0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      sa_idx = idx;
      sort_done = done;
      sa_valid = 1'b1;
      @(negedge clk);
      while (!sa_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!sa_ready) check("sa_ready_timeout", 64'(sa_ready), 64'd1);
      sa_cyc = cyc;
      @(posedge clk); #1;
      sa_valid = 1'b0;
      sort_done = 1'b0;
   endtask

   task automatic drain(input logic [3:0] pat, input int np);
      int n = 0;
      while (ob.size() < 2 && n < 60) begin
         out_ready = pat[2'(n % np)];
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
   endtask

   task automatic run_nom(input logic [3:0] pat, input int np, input logic early);
      ob.delete();
      ol.delete();
      op.delete();
      first_ov = -1;
      starts = 0;
      nstall = 0;
      send_beat(32'h616E6162, 1'b0);
      send_beat(32'h2461616E, 1'b1);
      if (early) begin
         int n = 0;
         @(negedge clk);
         while (!sa_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         check("collect_entry", 64'(sa_ready), 64'd1);
         @(posedge clk); #1;
         sort_done = 1'b1;
         @(posedge clk); #1;
         sort_done = 1'b0;
      end
      foreach (sa_tab[i]) send_sa(3'(sa_tab[i]), !early && i == 7, early ? 3 : 0);
      drain(pat, np);
      repeat (2) @(negedge clk);
      check("beat_count", 64'(ob.size()), 64'd2);
      if (ob.size() >= 2) begin
         check("beat0_data", 64'(ob[0]), 64'h6E6E6161);
         check("beat1_data", 64'(ob[1]), 64'h61612462);
         check("beat0_last", 64'(ol[0]), 64'd0);
         check("beat1_last", 64'(ol[1]), 64'd1);
         check("beat0_primary", 64'(op[0]), 64'd5);
         check("beat1_primary", 64'(op[1]), 64'd5);
      end
      check("start_latency", 64'(start_cyc - last_cyc), 64'd2);
      check("send_latency", 64'(first_ov - sa_cyc), 64'd1);
      check("start_count", 64'(starts), 64'd1);
      check("stall_count", 64'(nstall), np == 4 ? 64'd2 : 64'd0);
      check("nom_err", 64'(err), 64'd0);
      check("nom_busy", 64'(busy), 64'd0);
      check("sort_string", 64'(sort_string), 64'h2461616E616E6162);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_nom(4'b0001, 1, 1'b0);
      run_nom(4'b1001, 4, 1'b0);
      run_nom(4'b0001, 1, 1'b1);
      starts = 0;
      send_beat(32'h616E6162, 1'b1);
      @(negedge clk);
      check("frame_early_err", 64'(err), 64'd1);
      check("frame_early_busy", 64'(busy), 64'd0);
      repeat (4) @(negedge clk);
      check("frame_early_starts", 64'(starts), 64'd0);
      @(posedge clk); #1;
      send_beat(32'h616E6162, 1'b0);
      send_beat(32'h2461616E, 1'b0);
      @(negedge clk);
      check("frame_drop_busy", 64'(busy), 64'd1);
      check("frame_drop_err", 64'(err), 64'd1);
      @(posedge clk); #1;
      send_beat(32'h11223344, 1'b1);
      @(negedge clk);
      check("frame_end_busy", 64'(busy), 64'd0);
      check("frame_end_starts", 64'(starts), 64'd0);
      @(posedge clk); #1;
      run_nom(4'b0001, 1, 1'b0);
      starts = 0;
      send_beat(32'h246E6162, 1'b0);
      send_beat(32'h2461616E, 1'b1);
      repeat (3) @(negedge clk);
      check("sent_dup_err", 64'(err), 64'd2);
      check("sent_dup_busy", 64'(busy), 64'd0);
      check("sent_dup_starts", 64'(starts), 64'd0);
      @(posedge clk); #1;
      send_beat(32'h616E6162, 1'b0);
      send_beat(32'h6161616E, 1'b1);
      repeat (3) @(negedge clk);
      check("sent_none_err", 64'(err), 64'd2);
      check("sent_none_busy", 64'(busy), 64'd0);
      check("sent_none_starts", 64'(starts), 64'd0);
      @(posedge clk); #1;
      send_beat(32'h616E6162, 1'b0);
      send_beat(32'h2461616E, 1'b1);
      for (int i = 0; i < 3; i++) send_sa(3'(sa_tab[i]), 1'b0, 0);
      s0 = starts;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("post_reset_starts", 64'(starts), 64'(s0));
      check("post_reset_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      run_nom(4'b0001, 1, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
